// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver with frame-synchronous double-buffered loads.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan_driver #(
    parameter int NUM_DIGITS       = 4,
    parameter int REFRESH_DIV      = 2500,
    parameter int BLANK_CYCLES     = 4,
    parameter bit SEG_ACTIVE_LOW   = 1'b1,
    parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic                    i_Load,
    input  logic [4*NUM_DIGITS-1:0] i_Value,
    output logic                    o_Load_Ack,
    output logic                    o_Frame_Done,
    output logic [6:0]              o_Segment,
    output logic [NUM_DIGITS-1:0]   o_Digit_En
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] DIV_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIGITS - 1);
    localparam logic [6:0]    SEG_OFF   = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIGIT_ACTIVE_LOW}};

    logic [CW-1:0]           div_cnt;
    logic [DW-1:0]           dig_idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] display;
    logic                    pending;

    logic                    slot_end;
    logic                    frame_end;
    logic [3:0]              nibble;
    logic [6:0]              pattern;
    logic [NUM_DIGITS-1:0]   onehot;

    function automatic logic [6:0] decode(input logic [3:0] hex);
        case (hex)
            4'h0: decode = 7'h7E;
            4'h1: decode = 7'h30;
            4'h2: decode = 7'h6D;
            4'h3: decode = 7'h79;
            4'h4: decode = 7'h33;
            4'h5: decode = 7'h5B;
            4'h6: decode = 7'h5F;
            4'h7: decode = 7'h70;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h7B;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h1F;
            4'hC: decode = 7'h4E;
            4'hD: decode = 7'h3D;
            4'hE: decode = 7'h4F;
            default: decode = 7'h47;
        endcase
    endfunction

    assign slot_end  = (div_cnt == DIV_LAST);
    assign frame_end = slot_end && (dig_idx == DIG_LAST);
    assign nibble    = display[{dig_idx, 2'b00} +: 4];
    assign onehot    = NUM_DIGITS'(1) << dig_idx;

`ifdef SEG7_SCAN_LZB_EN
    // zero_from[k] is set when nibbles k..top of the live value are all zero
    logic [NUM_DIGITS-1:0] zero_from;
    logic                  blank_digit;

    always_comb begin
        zero_from = '0;
        zero_from[NUM_DIGITS-1] = (display[4*NUM_DIGITS-1 -: 4] == 4'h0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            zero_from[k] = zero_from[k+1] && (display[4*k +: 4] == 4'h0);
        end
    end

    assign blank_digit = (dig_idx != '0) && zero_from[dig_idx];
    assign pattern     = blank_digit ? 7'h00 : decode(nibble);
`else
    assign pattern = decode(nibble);
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            div_cnt      <= '0;
            dig_idx      <= '0;
            shadow       <= '0;
            display      <= '0;
            pending      <= 1'b0;
            o_Load_Ack   <= 1'b0;
            o_Frame_Done <= 1'b0;
            o_Segment    <= SEG_OFF;
            o_Digit_En   <= DIG_OFF;
        end else begin
            div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
            if (slot_end) begin
                dig_idx <= (dig_idx == DIG_LAST) ? '0 : dig_idx + 1'b1;
            end

            o_Frame_Done <= frame_end;
            o_Load_Ack   <= 1'b0;

            if (i_Load) begin
                shadow <= i_Value;
            end
            // A load coinciding with the boundary bypasses the shadow so the new frame shows it
            if (frame_end) begin
                if (i_Load) begin
                    display    <= i_Value;
                    pending    <= 1'b0;
                    o_Load_Ack <= 1'b1;
                end else if (pending) begin
                    display    <= shadow;
                    pending    <= 1'b0;
                    o_Load_Ack <= 1'b1;
                end
            end else if (i_Load) begin
                pending <= 1'b1;
            end

            o_Segment  <= SEG_ACTIVE_LOW ? ~pattern : pattern;
            o_Digit_En <= (div_cnt < BLANK_END) ? DIG_OFF
                                                : (DIGIT_ACTIVE_LOW ? ~onehot : onehot);
        end
    end

endmodule
